// File: rtl/xbar_sched_pkg.sv
// Shared types for the crossbar scheduler: index widths, per-output FSM state
// and the round-robin pointer increment.
package xbar_sched_pkg;

    localparam int NUM_INPUT_DFLT  = 4;
    localparam int NUM_OUTPUT_DFLT = 4;

    typedef logic [$clog2(NUM_INPUT_DFLT)-1:0]  in_idx_t;
    typedef logic [$clog2(NUM_OUTPUT_DFLT)-1:0] out_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Explicit wrap so non-power-of-two requester counts stay in range.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbar_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// searching upward with wrap. Returns one-hot and encoded grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_oh_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);
    localparam int IW = $clog2(NUM_REQ);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = idx;
            end
        end
    end

endmodule

// File: rtl/xbar_sched.sv
// Per-output round-robin scheduler driving the xbar select vector; each output
// holds its grant until the consumer accepts or the requester withdraws.
//
// state | meaning
// IDLE  | no grant; arbitrate among requesters targeting this output
// BUSY  | grant held in gnt_q, waiting for out_ready_i
module xbar_sched
    import xbar_sched_pkg::*;
#(
    parameter int NUM_INPUT  = NUM_INPUT_DFLT,
    parameter int NUM_OUTPUT = NUM_OUTPUT_DFLT
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NUM_INPUT-1:0]                         req_valid_i,
    input  logic [NUM_INPUT-1:0][$clog2(NUM_OUTPUT)-1:0] req_dest_i,
    output logic [NUM_INPUT-1:0]                         req_ready_o,
    output logic [NUM_OUTPUT-1:0]                        out_valid_o,
    input  logic [NUM_OUTPUT-1:0]                        out_ready_i,
    output logic [NUM_OUTPUT-1:0][$clog2(NUM_INPUT)-1:0] select_vector_o
);
    localparam int IW = $clog2(NUM_INPUT);
    localparam int OW = $clog2(NUM_OUTPUT);

    state_t         state_q [NUM_OUTPUT];
    state_t         state_d [NUM_OUTPUT];
    logic [IW-1:0]  gnt_q   [NUM_OUTPUT];
    logic [IW-1:0]  gnt_d   [NUM_OUTPUT];
    logic [IW-1:0]  ptr_q   [NUM_OUTPUT];
    logic [IW-1:0]  ptr_d   [NUM_OUTPUT];

    logic [NUM_INPUT-1:0] cand    [NUM_OUTPUT];
    logic [NUM_INPUT-1:0] arb_oh  [NUM_OUTPUT];
    logic [IW-1:0]        arb_idx [NUM_OUTPUT];

    always_comb begin
        for (int o = 0; o < NUM_OUTPUT; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NUM_INPUT; i++) begin
                cand[o][i] = req_valid_i[i] && (req_dest_i[i] == OW'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_arb
        rr_arbiter #(
            .NUM_REQ (NUM_INPUT)
        ) u_arb (
            .req_i     (cand[o]),
            .ptr_i     (ptr_q[o]),
            .gnt_oh_o  (arb_oh[o]),
            .gnt_idx_o (arb_idx[o])
        );
    end

    logic hold;

    always_comb begin
        req_ready_o = '0;
        hold        = 1'b0;
        for (int o = 0; o < NUM_OUTPUT; o++) begin
            state_d[o]         = state_q[o];
            gnt_d[o]           = gnt_q[o];
            ptr_d[o]           = ptr_q[o];
            out_valid_o[o]     = 1'b0;
            select_vector_o[o] = gnt_q[o];
            case (state_q[o])
                IDLE: begin
                    if (|arb_oh[o]) begin
                        gnt_d[o]   = arb_idx[o];
                        state_d[o] = BUSY;
                    end
                end
                BUSY: begin
                    // A withdrawn request suppresses valid in the same cycle so
                    // the consumer never sees data the requester no longer drives.
                    hold           = req_valid_i[gnt_q[o]];
                    out_valid_o[o] = hold && !rst_i;
                    if (!hold) begin
                        state_d[o] = IDLE;
                    end else if (out_ready_i[o]) begin
                        if (!rst_i) begin
                            req_ready_o[gnt_q[o]] = 1'b1;
                        end
                        ptr_d[o]   = IW'(wrap_inc(32'(gnt_q[o]), NUM_INPUT));
                        state_d[o] = IDLE;
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int o = 0; o < NUM_OUTPUT; o++) begin
            if (rst_i) begin
                state_q[o] <= IDLE;
                gnt_q[o]   <= '0;
                ptr_q[o]   <= '0;
            end else begin
                state_q[o] <= state_d[o];
                gnt_q[o]   <= gnt_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_xbar_sched.sv
// Self-checking bench for xbar_sched: per-cycle reference model plus directed
// scenarios with hand-computed expectations.
module tb_xbar_sched;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [3:0]      req_valid_i;
    logic [3:0][1:0] req_dest_i;
    logic [3:0]      req_ready_o;
    logic [3:0]      out_valid_o;
    logic [3:0]      out_ready_i;
    logic [3:0][1:0] select_vector_o;

    int n_checks = 0;
    int n_errors = 0;

    xbar_sched #(
        .NUM_INPUT  (4),
        .NUM_OUTPUT (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_dest_i      (req_dest_i),
        .req_ready_o     (req_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .select_vector_o (select_vector_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per output, whether a grant is held, which requester
    // holds it, and where the next round-robin search starts.
    bit m_busy [4];
    int m_gnt  [4];
    int m_ptr  [4];

    initial begin
        for (int o = 0; o < 4; o++) begin
            m_busy[o] = 1'b0;
            m_gnt[o]  = 0;
            m_ptr[o]  = 0;
        end
    end

    logic [3:0]      ev, er;
    logic [3:0][1:0] es;
    bit              found;

    always @(negedge clk) begin
        ev = '0;
        er = '0;
        es = '0;
        for (int o = 0; o < 4; o++) begin
            es[o] = 2'(m_gnt[o]);
            if (!rst_i && m_busy[o] && req_valid_i[m_gnt[o]]) begin
                ev[o] = 1'b1;
                if (out_ready_i[o]) er[m_gnt[o]] = 1'b1;
            end
        end
        check("model_out_valid", 32'(out_valid_o), 32'(ev));
        check("model_req_ready", 32'(req_ready_o), 32'(er));
        check("model_select", 32'(select_vector_o), 32'(es));

        for (int o = 0; o < 4; o++) begin
            if (rst_i) begin
                m_busy[o] = 1'b0;
                m_gnt[o]  = 0;
                m_ptr[o]  = 0;
            end else if (!m_busy[o]) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % 4;
                    if (!found && req_valid_i[i] && int'(req_dest_i[i]) == o) begin
                        found     = 1'b1;
                        m_gnt[o]  = i;
                        m_busy[o] = 1'b1;
                    end
                end
            end else if (!req_valid_i[m_gnt[o]]) begin
                m_busy[o] = 1'b0;
            end else if (out_ready_i[o]) begin
                m_busy[o] = 1'b0;
                m_ptr[o]  = (m_gnt[o] + 1) % 4;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    int exp_order [5];
    int pulses;

    initial begin
        exp_order = '{0, 1, 3, 0, 1};

        // Reset with random requests
        rst_i       = 1'b1;
        req_valid_i = 4'($urandom);
        req_dest_i  = 8'($urandom);
        out_ready_i = 4'($urandom);
        for (int c = 0; c < 2; c++) begin
            neg();
            check("rst_out_valid", 32'(out_valid_o), 32'h0);
            check("rst_req_ready", 32'(req_ready_o), 32'h0);
            check("rst_select", 32'(select_vector_o), 32'h0);
            cyc();
            req_valid_i = 4'($urandom);
            req_dest_i  = 8'($urandom);
            out_ready_i = 4'($urandom);
        end
        rst_i       = 1'b0;
        req_valid_i = '0;
        req_dest_i  = '0;
        out_ready_i = '0;
        cyc();

        // Single transfer: requester 2 -> output 1
        req_valid_i   = 4'b0100;
        req_dest_i[2] = 2'd1;
        out_ready_i   = 4'b0010;
        neg();
        check("single_c0_valid", 32'(out_valid_o), 32'h0);
        cyc();
        neg();
        check("single_c1_valid", 32'(out_valid_o[1]), 32'h1);
        check("single_c1_sel", 32'(select_vector_o[1]), 32'h2);
        check("single_c1_ready", 32'(req_ready_o), 32'h4);
        cyc();
        req_valid_i = '0;
        neg();
        check("single_c2_valid", 32'(out_valid_o[1]), 32'h0);
        cyc();
        out_ready_i = '0;
        cyc();

        // Contention on output 0 from requesters 0, 1, 3
        req_dest_i  = '0;
        req_valid_i = 4'b1011;
        out_ready_i = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            neg();
            if (c % 2 == 1) begin
                check("cont_valid", 32'(out_valid_o[0]), 32'h1);
                check("cont_sel", 32'(select_vector_o[0]), 32'(exp_order[c / 2]));
                check("cont_ready", 32'(req_ready_o), 32'(1 << exp_order[c / 2]));
            end else begin
                check("cont_gap_valid", 32'(out_valid_o[0]), 32'h0);
            end
            cyc();
        end
        req_valid_i = '0;
        out_ready_i = '0;
        check("cont_model_ptr0", 32'(m_ptr[0]), 32'h2);
        cyc();

        // All four requesters to distinct outputs at once
        req_dest_i[0] = 2'd3;
        req_dest_i[1] = 2'd2;
        req_dest_i[2] = 2'd1;
        req_dest_i[3] = 2'd0;
        req_valid_i   = 4'hF;
        neg();
        check("par_c0_valid", 32'(out_valid_o), 32'h0);
        cyc();
        neg();
        check("par_c1_valid", 32'(out_valid_o), 32'hF);
        check("par_c1_sel", 32'(select_vector_o), 32'h1B);
        check("par_c1_ready", 32'(req_ready_o), 32'h0);
        cyc();
        out_ready_i = 4'hF;
        neg();
        check("par_c2_ready", 32'(req_ready_o), 32'hF);
        cyc();
        req_valid_i = '0;
        out_ready_i = '0;
        cyc();

        // Backpressure on output 2
        req_dest_i[1] = 2'd2;
        req_valid_i   = 4'b0010;
        pulses        = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 6) out_ready_i = 4'b0100;
            if (c == 7) begin
                req_valid_i = '0;
                out_ready_i = '0;
            end
            neg();
            pulses += int'(req_ready_o[1]);
            if (c >= 1 && c <= 5) begin
                check("bp_valid", 32'(out_valid_o[2]), 32'h1);
                check("bp_sel", 32'(select_vector_o[2]), 32'h1);
                check("bp_no_ready", 32'(req_ready_o[1]), 32'h0);
            end
            if (c == 6) check("bp_ready", 32'(req_ready_o[1]), 32'h1);
            cyc();
        end
        check("bp_pulses", 32'(pulses), 32'h1);

        // Valid drop while BUSY on output 3; pointer must not advance
        req_dest_i[0] = 2'd3;
        req_dest_i[2] = 2'd3;
        req_valid_i   = 4'b0101;
        neg();
        cyc();
        neg();
        check("abort_c1_valid", 32'(out_valid_o[3]), 32'h1);
        check("abort_c1_sel", 32'(select_vector_o[3]), 32'h2);
        cyc();
        req_valid_i = 4'b0001;
        neg();
        check("abort_c2_valid", 32'(out_valid_o[3]), 32'h0);
        check("abort_c2_ready", 32'(req_ready_o), 32'h0);
        cyc();
        req_valid_i = 4'b0101;
        neg();
        check("abort_c3_valid", 32'(out_valid_o[3]), 32'h0);
        cyc();
        out_ready_i = 4'b1000;
        neg();
        check("abort_c4_valid", 32'(out_valid_o[3]), 32'h1);
        check("abort_c4_sel", 32'(select_vector_o[3]), 32'h2);
        check("abort_c4_ready", 32'(req_ready_o), 32'h4);
        cyc();
        req_valid_i = '0;
        out_ready_i = '0;
        neg();
        check("abort_model_ptr3", 32'(m_ptr[3]), 32'h3);
        cyc();

        // Reset mid-BUSY beats a simultaneous handshake
        req_dest_i[1] = 2'd0;
        req_valid_i   = 4'b0010;
        neg();
        cyc();
        neg();
        check("rstb_c1_valid", 32'(out_valid_o[0]), 32'h1);
        check("rstb_c1_sel", 32'(select_vector_o[0]), 32'h1);
        cyc();
        rst_i       = 1'b1;
        out_ready_i = 4'b0001;
        neg();
        check("rstb_c2_valid", 32'(out_valid_o), 32'h0);
        check("rstb_c2_ready", 32'(req_ready_o), 32'h0);
        cyc();
        rst_i       = 1'b0;
        req_valid_i = '0;
        out_ready_i = '0;
        neg();
        check("rstb_c3_valid", 32'(out_valid_o), 32'h0);
        check("rstb_c3_sel", 32'(select_vector_o), 32'h0);
        check("rstb_c3_ready", 32'(req_ready_o), 32'h0);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
